// File: rtl/uart_rx_cfg_if.sv
// Receive-side bundle for uart_rx_cfg: serial line in, decoded frame out.
// master = receiver (drives the po_* outputs), slave = pin driver / consumer.
interface uart_rx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] po_data;
  logic                 po_flag;
  logic                 po_parity_err;
  logic                 po_frame_err;

  modport master (input rx, output po_data, po_flag, po_parity_err, po_frame_err);
  modport slave  (output rx, input po_data, po_flag, po_parity_err, po_frame_err);
endinterface

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 5..9 data bits, optional parity, 1/2 stop bits, error flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions (adds one cycle of latency).
module uart_rx_cfg #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned UART_BPS  = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input logic           sys_clk,
  input logic           sys_rst_n,
  uart_rx_cfg_if.master rx_if
);
  localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int unsigned CNT_W        = $clog2(BAUD_CNT_MAX);
  localparam int unsigned BIT_W        = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(BAUD_CNT_MAX / 2);
`else
  localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(BAUD_CNT_MAX / 2 - 1);
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state;
  logic                 rx_s1, rx_s2, rx_s3;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_err, frm_err;
  logic [DATA_BITS-1:0] data_q;
  logic                 flag_q, perr_q, ferr_q;
  logic                 bit_val;
  logic                 strobe;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx_if.rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist[1]/hist[0] hold the two samples preceding the decision cycle
  logic [1:0] maj_hist;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) maj_hist <= '1;
    else            maj_hist <= {maj_hist[0], rx_s2};
  end

  assign bit_val = (maj_hist[1] & maj_hist[0]) | (maj_hist[1] & rx_s2) | (maj_hist[0] & rx_s2);
`else
  assign bit_val = rx_s2;
`endif

  assign strobe = (state != S_IDLE) && (baud_cnt == SAMPLE_AT);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      data_q   <= '0;
      flag_q   <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      flag_q   <= 1'b0;
      baud_cnt <= (state == S_IDLE || baud_cnt == CNT_LAST) ? '0 : baud_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            state   <= S_START;
            par_err <= 1'b0;
            frm_err <= 1'b0;
          end
        end
        S_START: begin
          if (strobe) begin
            if (bit_val) begin
              state    <= S_IDLE;
              baud_cnt <= '0;
            end else begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
        end
        S_DATA: begin
          if (strobe) begin
            shift <= {bit_val, shift[DATA_BITS-1:1]};
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
              bit_cnt  <= '0;
              stop_cnt <= 1'b0;
              state    <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (strobe) begin
            par_err <= ((^shift) ^ bit_val) != (PARITY == 32'd1);
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (strobe) begin
            // Last stop sample publishes the frame and frees the FSM for a back-to-back start
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              state    <= S_IDLE;
              baud_cnt <= '0;
              stop_cnt <= 1'b0;
              flag_q   <= 1'b1;
              data_q   <= shift;
              perr_q   <= par_err;
              ferr_q   <= frm_err | ~bit_val;
            end else begin
              stop_cnt <= 1'b1;
              frm_err  <= frm_err | ~bit_val;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          baud_cnt <= '0;
        end
      endcase
    end
  end

  assign rx_if.po_data       = data_q;
  assign rx_if.po_flag       = flag_q;
  assign rx_if.po_parity_err = perr_q;
  assign rx_if.po_frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: four configurations (8N1, 8E2, 7N1, 9O1) driven
// in parallel, every po_flag checked against an expected-frame FIFO built from the sent bits.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
  localparam int unsigned CLK_FREQ = 50_000_000;
  localparam int unsigned UART_BPS = 115_200;
  localparam int unsigned BAUD     = CLK_FREQ / UART_BPS;
  localparam int unsigned HALF     = BAUD / 2;
  localparam int unsigned NU       = 4;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned MAJ = 1;
`else
  localparam int unsigned MAJ = 0;
`endif

  typedef struct {
    logic [8:0]  data;
    logic        perr;
    logic        ferr;
    int unsigned cyc;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        rst2_n;
  logic        rst_u2_n;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  exp_t        exp_mem [NU][32];
  int unsigned wr_p [NU];
  int unsigned rd_p [NU];

  logic       flag_o [NU];
  logic [8:0] data_o [NU];
  logic       perr_o [NU];
  logic       ferr_o [NU];

  always #10 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  assign rst_u2_n = sys_rst_n & rst2_n;

  uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if2 ();
  uart_rx_cfg_if #(.DATA_BITS(9)) if3 ();

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u0 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_if(if0));
  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2))
    u1 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_if(if1));
  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1))
    u2 (.sys_clk(sys_clk), .sys_rst_n(rst_u2_n), .rx_if(if2));
  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1))
    u3 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_if(if3));

  assign flag_o[0] = if0.po_flag;  assign data_o[0] = 9'(if0.po_data);
  assign flag_o[1] = if1.po_flag;  assign data_o[1] = 9'(if1.po_data);
  assign flag_o[2] = if2.po_flag;  assign data_o[2] = 9'(if2.po_data);
  assign flag_o[3] = if3.po_flag;  assign data_o[3] = 9'(if3.po_data);
  assign perr_o[0] = if0.po_parity_err;  assign ferr_o[0] = if0.po_frame_err;
  assign perr_o[1] = if1.po_parity_err;  assign ferr_o[1] = if1.po_frame_err;
  assign perr_o[2] = if2.po_parity_err;  assign ferr_o[2] = if2.po_frame_err;
  assign perr_o[3] = if3.po_parity_err;  assign ferr_o[3] = if3.po_frame_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned db_of(input int unsigned u);
    case (u)
      0, 1:    return 8;
      2:       return 7;
      default: return 9;
    endcase
  endfunction

  function automatic int unsigned par_of(input int unsigned u);
    case (u)
      1:       return 2;
      3:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned sb_of(input int unsigned u);
    return (u == 1) ? 2 : 1;
  endfunction

  task automatic drive_rx(input int unsigned u, input logic v);
    case (u)
      0:       if0.rx = v;
      1:       if1.rx = v;
      2:       if2.rx = v;
      default: if3.rx = v;
    endcase
  endtask

  task automatic idle(input int unsigned u, input int unsigned n);
    drive_rx(u, 1'b1);
    repeat (n) @(negedge sys_clk);
  endtask

  // Drives one frame starting at the current negedge; glitch = frame bit index to
  // invert for a single cycle at its centre (-1: none). stops[0] is the first stop bit.
  task automatic send_frame(input int unsigned u, input logic [8:0] d, input logic pbit,
                            input logic [1:0] stops, input int glitch, input bit expect_flag);
    int unsigned db  = db_of(u);
    int unsigned par = par_of(u);
    int unsigned sb  = sb_of(u);
    logic        fr [16];
    int unsigned n   = 0;
    logic [8:0]  ed;
    exp_t        e;
    fr[n++] = 1'b0;
    for (int unsigned i = 0; i < db; i++) fr[n++] = d[i];
    if (par != 0) fr[n++] = pbit;
    for (int unsigned i = 0; i < sb; i++) fr[n++] = stops[i];
    ed = d & 9'((1 << db) - 1);
    if (MAJ == 0 && glitch >= 1 && glitch <= int'(db)) ed[glitch-1] = ~ed[glitch-1];
    e.data = ed;
    e.perr = (par != 0) && (((^ed) ^ pbit) != (par == 1));
    e.ferr = !stops[0] || (sb == 2 && !stops[1]);
    e.cyc  = cyc + 3 + HALF + MAJ + (n - 1) * BAUD;
    if (expect_flag) begin
      exp_mem[u][wr_p[u] % 32] = e;
      wr_p[u]++;
    end
    for (int unsigned k = 0; k < n; k++) begin
      drive_rx(u, fr[k]);
      if (glitch == int'(k)) begin
        repeat (HALF) @(negedge sys_clk);
        drive_rx(u, ~fr[k]);
        @(negedge sys_clk);
        drive_rx(u, fr[k]);
        repeat (BAUD - HALF - 1) @(negedge sys_clk);
      end else begin
        repeat (BAUD) @(negedge sys_clk);
      end
    end
  endtask

  task automatic rand_frame(input int unsigned u);
    logic [8:0] d     = 9'($urandom);
    logic       good  = (^(d & 9'((1 << db_of(u)) - 1))) ^ (par_of(u) == 1);
    logic       pbit  = good ^ ($urandom_range(0, 3) == 0);
    logic [1:0] stops = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
    send_frame(u, d, pbit, stops, -1, 1'b1);
    idle(u, 2 + $urandom_range(0, 40));
  endtask

  task automatic run_u0();
    send_frame(0, 9'hA5, 1'b0, 2'b11, -1, 1'b1);
    idle(0, 20);
    drive_rx(0, 1'b0);
    repeat (100) @(negedge sys_clk);
    idle(0, 2 * BAUD);
    send_frame(0, 9'h3C, 1'b0, 2'b11, -1, 1'b1);
    idle(0, 20);
    send_frame(0, 9'h00, 1'b0, 2'b11, 4, 1'b1);
    idle(0, 20);
    // break: line held low well past one frame
    send_frame(0, 9'h00, 1'b0, 2'b00, -1, 1'b1);
    drive_rx(0, 1'b0);
    repeat (3 * BAUD) @(negedge sys_clk);
    idle(0, BAUD);
    repeat (3) rand_frame(0);
  endtask

  task automatic run_u1();
    send_frame(1, 9'h37, 1'b1, 2'b11, -1, 1'b1);
    idle(1, 10);
    send_frame(1, 9'h37, 1'b0, 2'b11, -1, 1'b1);
    idle(1, 10);
    send_frame(1, 9'h5A, 1'b0, 2'b01, -1, 1'b1);
    idle(1, 20);
    repeat (3) rand_frame(1);
  endtask

  task automatic run_u2();
    send_frame(2, 9'h41, 1'b0, 2'b11, -1, 1'b1);
    send_frame(2, 9'h7F, 1'b0, 2'b11, -1, 1'b1);
    idle(2, 20);
    // abort a frame part-way with reset; rx released high so no start edge follows
    drive_rx(2, 1'b0);
    repeat (3 * BAUD) @(negedge sys_clk);
    rst2_n = 1'b0;
    drive_rx(2, 1'b1);
    repeat (5) @(negedge sys_clk);
    check("u2_rst_data", 32'(data_o[2]), 32'h0);
    check("u2_rst_flag", 32'(flag_o[2]), 32'h0);
    check("u2_rst_perr", 32'(perr_o[2]), 32'h0);
    check("u2_rst_ferr", 32'(ferr_o[2]), 32'h0);
    rst2_n = 1'b1;
    idle(2, 10 * BAUD);
    send_frame(2, 9'h2A, 1'b0, 2'b11, -1, 1'b1);
    idle(2, 10);
    repeat (3) rand_frame(2);
  endtask

  task automatic run_u3();
    send_frame(3, 9'h1FF, 1'b0, 2'b11, -1, 1'b1);
    idle(3, 10);
    repeat (4) rand_frame(3);
  endtask

  // Every po_flag must match the oldest outstanding frame, including its arrival cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      for (int unsigned u = 0; u < NU; u++) begin
        if (flag_o[u]) begin
          if (rd_p[u] == wr_p[u]) begin
            check($sformatf("u%0d_unexpected_flag", u), 32'(flag_o[u]), 32'h0);
          end else begin
            e = exp_mem[u][rd_p[u] % 32];
            rd_p[u]++;
            check($sformatf("u%0d_data", u), 32'(data_o[u]), 32'(e.data));
            check($sformatf("u%0d_perr", u), 32'(perr_o[u]), 32'(e.perr));
            check($sformatf("u%0d_ferr", u), 32'(ferr_o[u]), 32'(e.ferr));
            check($sformatf("u%0d_flag_cycle", u), cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    repeat (90_000) @(posedge sys_clk);
    n_errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int unsigned u = 0; u < NU; u++) begin
      wr_p[u] = 0;
      rd_p[u] = 0;
      drive_rx(u, 1'b1);
    end
    sys_rst_n = 1'b0;
    rst2_n    = 1'b1;
    repeat (5) @(negedge sys_clk);
    for (int unsigned u = 0; u < NU; u++) begin
      check($sformatf("u%0d_reset_flag", u), 32'(flag_o[u]), 32'h0);
      check($sformatf("u%0d_reset_data", u), 32'(data_o[u]), 32'h0);
      check($sformatf("u%0d_reset_perr", u), 32'(perr_o[u]), 32'h0);
      check($sformatf("u%0d_reset_ferr", u), 32'(ferr_o[u]), 32'h0);
    end
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    fork
      run_u0();
      run_u1();
      run_u2();
      run_u3();
    join
    repeat (BAUD) @(negedge sys_clk);
    for (int unsigned u = 0; u < NU; u++)
      check($sformatf("u%0d_missing_flags", u), wr_p[u] - rd_p[u], 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
